// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, multi-cycle EX and flush requests.
// Optional macro STALL_PERF_EN adds a saturating stalled-cycle counter output.
module pipe_stall_ctrl #(
  parameter int unsigned MC_CNT_W  = 6,
  parameter int unsigned FLUSH_LEN = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id_i,
  input  logic                mc_start_i,
  input  logic [MC_CNT_W-1:0] mc_cycles_i,
  input  logic                mc_cancel_i,
  input  logic                flush_req_i,
  output logic [5:0]          stall_o,
  output logic                flush_o,
  output logic                mc_busy_o,
  output logic                mc_done_o,
  output logic [MC_CNT_W-1:0] mc_cnt_o
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt_o
`endif
);

  localparam int unsigned FlW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StFlush} state_e;

  state_e              state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  logic [FlW-1:0]      fcnt_q, fcnt_d;
  logic [MC_CNT_W-1:0] len_eff;
  logic                ex_stall;

  assign len_eff = (mc_cycles_i == '0) ? MC_CNT_W'(1) : mc_cycles_i;

  // The start cycle itself counts as the first EX cycle, so BUSY covers L-2 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    if (state_q != StFlush && flush_req_i) begin
      state_d = StFlush;
      cnt_d   = '0;
      fcnt_d  = FlW'(FLUSH_LEN - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mc_start_i) begin
            if (len_eff > MC_CNT_W'(2)) begin
              state_d = StBusy;
              cnt_d   = len_eff - MC_CNT_W'(2);
            end else begin
              state_d = StDone;
            end
          end
        end
        StBusy: begin
          if (mc_cancel_i) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            if (cnt_q != '0) cnt_d = cnt_q - MC_CNT_W'(1);
            if (cnt_q <= MC_CNT_W'(1)) state_d = StDone;
          end
        end
        StDone: state_d = StIdle;
        StFlush: begin
          if (fcnt_q == '0) state_d = StIdle;
          else              fcnt_d  = fcnt_q - FlW'(1);
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign ex_stall = (state_q == StIdle && mc_start_i && len_eff > MC_CNT_W'(1)) ||
                    (state_q == StBusy);

  always_comb begin
    stall_o = 6'b000000;
    if (flush_req_i || state_q == StFlush) stall_o = 6'b000000;
    else if (ex_stall)                     stall_o = 6'b001111;
    else if (stallreq_id_i)                stall_o = 6'b000111;
  end

  assign mc_busy_o = ex_stall;
  assign flush_o   = (state_q == StFlush);
  assign mc_done_o = (state_q == StDone);
  assign mc_cnt_o  = cnt_q;

`ifdef STALL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (stall_o != 6'b000000 && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_q <= '0;
    else      perf_q <= perf_d;
  end

  assign perf_stall_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl; inputs change on the falling edge, outputs checked 1ns later.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_id_i, mc_start_i, mc_cancel_i, flush_req_i;
  logic [5:0] mc_cycles_i;
  logic [5:0] stall_o;
  logic       flush_o, mc_busy_o, mc_done_o;
  logic [5:0] mc_cnt_o;
`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_cnt_o;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // {stall, flush, busy, done, cnt}
  logic [14:0] obs;
  assign obs = {stall_o, flush_o, mc_busy_o, mc_done_o, mc_cnt_o};

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_id_i (stallreq_id_i),
    .mc_start_i    (mc_start_i),
    .mc_cycles_i   (mc_cycles_i),
    .mc_cancel_i   (mc_cancel_i),
    .flush_req_i   (flush_req_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .mc_busy_o     (mc_busy_o),
    .mc_done_o     (mc_done_o),
    .mc_cnt_o      (mc_cnt_o)
`ifdef STALL_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  task automatic clear_inputs();
    stallreq_id_i = 1'b0;
    mc_start_i    = 1'b0;
    mc_cancel_i   = 1'b0;
    flush_req_i   = 1'b0;
    mc_cycles_i   = 6'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    mc_start_i = 1'b1; mc_cycles_i = 6'd7;
    @(negedge clk);
    clear_inputs();
    #1;
    if (obs !== {6'b001111, 1'b0, 1'b1, 1'b0, 6'd5}) begin
      $display("FAIL reset_pre_busy: got %h want %h", obs, {6'b001111, 3'b010, 6'd5});
      n_fail++;
    end
    n_cmp++;
    #1 rst = 1'b0;
    #1;
    if (obs !== 15'd0) begin
      $display("FAIL reset_async: got %h want %h", obs, 15'd0);
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    if (obs !== 15'd0) begin
      $display("FAIL reset_release: got %h want %h", obs, 15'd0);
      n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_multicycle();
    logic [14:0] exp4 [5];
    logic [14:0] exps [3];
    logic [14:0] exp2 [3];
    logic [5:0]  lens [2];
    exp4 = '{{6'b001111, 3'b010, 6'd0}, {6'b001111, 3'b010, 6'd2},
             {6'b001111, 3'b010, 6'd1}, {6'b000000, 3'b001, 6'd0},
             {6'b000000, 3'b000, 6'd0}};
    exps = '{15'd0, {6'b000000, 3'b001, 6'd0}, 15'd0};
    exp2 = '{{6'b001111, 3'b010, 6'd0}, {6'b000000, 3'b001, 6'd0}, 15'd0};
    lens = '{6'd0, 6'd1};
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      mc_start_i = (i == 0); mc_cycles_i = 6'd4;
      #1;
      if (obs !== exp4[i]) begin
        $display("FAIL mc_len4 cyc%0d: got %h want %h", i, obs, exp4[i]);
        n_fail++;
      end
      n_cmp++;
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        mc_start_i = (i == 0); mc_cycles_i = lens[k];
        #1;
        if (obs !== exps[i]) begin
          $display("FAIL mc_len%0d cyc%0d: got %h want %h", lens[k], i, obs, exps[i]);
          n_fail++;
        end
        n_cmp++;
        @(negedge clk);
      end
    end
    for (int i = 0; i < 3; i++) begin
      mc_start_i = (i == 0); mc_cycles_i = 6'd2;
      #1;
      if (obs !== exp2[i]) begin
        $display("FAIL mc_len2 cyc%0d: got %h want %h", i, obs, exp2[i]);
        n_fail++;
      end
      n_cmp++;
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_id_stall();
    @(negedge clk);
    stallreq_id_i = 1'b1;
    #1;
    if (stall_o !== 6'b000111) begin
      $display("FAIL id_stall_alone: got %b want %b", stall_o, 6'b000111);
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    stallreq_id_i = 1'b0; mc_start_i = 1'b1; mc_cycles_i = 6'd4;
    @(negedge clk);
    mc_start_i = 1'b0; stallreq_id_i = 1'b1;
    #1;
    if (obs !== {6'b001111, 3'b010, 6'd2}) begin
      $display("FAIL id_stall_busy: got %h want %h", obs, {6'b001111, 3'b010, 6'd2});
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    @(negedge clk);
    stallreq_id_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cancel();
    logic saw_done = 1'b0;
    @(negedge clk);
    mc_start_i = 1'b1; mc_cycles_i = 6'd5;
    @(negedge clk);
    mc_start_i = 1'b0; mc_cancel_i = 1'b1;
    #1;
    if (mc_cnt_o !== 6'd3) begin
      $display("FAIL cancel_cnt_before: got %0d want %0d", mc_cnt_o, 3);
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    mc_cancel_i = 1'b0;
    #1;
    if (obs !== 15'd0) begin
      $display("FAIL cancel_idle: got %h want %h", obs, 15'd0);
      n_fail++;
    end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (mc_done_o) saw_done = 1'b1;
    end
    if (saw_done !== 1'b0) begin
      $display("FAIL cancel_no_done: got %b want %b", saw_done, 1'b0);
      n_fail++;
    end
    n_cmp++;
  endtask

  task automatic test_flush();
    logic [14:0] exp [8];
    exp = '{{6'b001111, 3'b010, 6'd0}, {6'b000000, 3'b010, 6'd3},
            {6'b000000, 3'b100, 6'd0}, {6'b000000, 3'b100, 6'd0},
            {6'b001111, 3'b010, 6'd0}, {6'b001111, 3'b010, 6'd2},
            {6'b001111, 3'b010, 6'd1}, {6'b000000, 3'b001, 6'd0}};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      case (i)
        0: begin mc_start_i = 1'b1; mc_cycles_i = 6'd5; end
        1: begin flush_req_i = 1'b1; stallreq_id_i = 1'b1; end
        2, 3: begin
          flush_req_i = 1'b1; stallreq_id_i = 1'b1;
          mc_start_i = 1'b1; mc_cycles_i = 6'd4;
        end
        4: begin mc_start_i = 1'b1; mc_cycles_i = 6'd4; end
        default: ;
      endcase
      #1;
      if (obs !== exp[i]) begin
        $display("FAIL flush cyc%0d: got %h want %h", i, obs, exp[i]);
        n_fail++;
      end
      n_cmp++;
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    mc_start_i = 1'b1; mc_cycles_i = 6'd2;
    @(negedge clk);
    mc_cycles_i = 6'd4;
    #1;
    if (obs !== {6'b000000, 3'b001, 6'd0}) begin
      $display("FAIL b2b_done_ignores_start: got %h want %h", obs, {6'b000000, 3'b001, 6'd0});
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    clear_inputs();
    #1;
    if (obs !== 15'd0) begin
      $display("FAIL b2b_idle_after: got %h want %h", obs, 15'd0);
      n_fail++;
    end
    n_cmp++;
  endtask

`ifdef STALL_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stallreq_id_i = 1'b1;
      @(negedge clk);
    end
    stallreq_id_i = 1'b0; mc_start_i = 1'b1; mc_cycles_i = 6'd5;
    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 5; i++) @(negedge clk);
    #1;
    if (perf_stall_cnt_o !== 32'd7) begin
      $display("FAIL perf_count: got %0d want %0d", perf_stall_cnt_o, 7);
      n_fail++;
    end
    n_cmp++;
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b0;
    #1;
    if (obs !== 15'd0) begin
      $display("FAIL reset_initial: got %h want %h", obs, 15'd0);
      n_fail++;
    end
    n_cmp++;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    test_reset();
    test_multicycle();
    test_id_stall();
    test_cancel();
    test_flush();
    test_back_to_back();
`ifdef STALL_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
